// File: rtl/uart_serial_ctrl_pkg.sv
// uart_serial_ctrl_pkg: shared bus constants and types for the serial controller
package uart_serial_ctrl_pkg;
    localparam logic MEM_WRITE = 1'b1;
    localparam logic MEM_READ = 1'b0;
    localparam logic ENABLE = 1'b1;
    localparam int MEM_BUS = 16;
    localparam int SERIAL_DEFAULT_CLK_DIV = 1250;
    typedef logic [7:0] byte_t;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with input synchronizer, start-glitch rejection and stop check
module uart_rx import uart_serial_ctrl_pkg::*; #(
    parameter int CLK_DIV = SERIAL_DEFAULT_CLK_DIV
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  rxd,
    output logic  valid,
    output byte_t data
);
    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA = 2'd2;
    localparam logic [1:0] RX_STOP = 2'd3;
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          sync1, rxs, wrap;

    assign wrap = cnt == LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs <= 1'b1;
            state <= RX_IDLE;
            cnt <= '0;
            bit_idx <= '0;
            data <= '0;
            valid <= 1'b0;
        end else begin
            sync1 <= rxd;
            rxs <= sync1;
            valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rxs) state <= RX_START;
                end
                RX_START: begin
                    // Half a bit in: a line back high was only a glitch
                    cnt <= (cnt == HALF) ? '0 : cnt + 1'b1;
                    if (cnt == HALF) begin
                        state <= rxs ? RX_IDLE : RX_DATA;
                        bit_idx <= '0;
                    end
                end
                RX_DATA: begin
                    cnt <= wrap ? '0 : cnt + 1'b1;
                    if (wrap) begin
                        data <= {rxs, data[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end
                end
                default: begin
                    cnt <= wrap ? '0 : cnt + 1'b1;
                    if (wrap) begin
                        valid <= rxs;
                        state <= RX_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter with its own baud counter, restarted on each frame
module uart_tx import uart_serial_ctrl_pkg::*; #(
    parameter int CLK_DIV = SERIAL_DEFAULT_CLK_DIV
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  byte_t data,
    output logic  txd,
    output logic  ready
);
    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA = 2'd2;
    localparam logic [1:0] TX_STOP = 2'd3;
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    byte_t         shift;
    logic          wrap;

    assign wrap = cnt == LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= TX_IDLE;
            cnt <= '0;
            bit_idx <= '0;
            shift <= '0;
            txd <= 1'b1;
            ready <= 1'b1;
        end else begin
            // Holding the counter at zero while idle gives every frame a fresh bit period
            cnt <= (state == TX_IDLE || wrap) ? '0 : cnt + 1'b1;
            case (state)
                TX_IDLE: if (start) begin
                    state <= TX_START;
                    shift <= data;
                    txd <= 1'b0;
                    ready <= 1'b0;
                end
                TX_START: if (wrap) begin
                    state <= TX_DATA;
                    bit_idx <= '0;
                    txd <= shift[0];
                    shift <= shift >> 1;
                end
                TX_DATA: if (wrap) begin
                    if (bit_idx == 3'd7) begin
                        state <= TX_STOP;
                        txd <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        txd <= shift[0];
                        shift <= shift >> 1;
                    end
                end
                default: if (wrap) begin
                    state <= TX_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_serial_ctrl.sv
// uart_serial_ctrl: MMU-facing serial port with 8N1 TX/RX and a one-byte receive holding register
module uart_serial_ctrl import uart_serial_ctrl_pkg::*; #(
    parameter int CLK_DIV = SERIAL_DEFAULT_CLK_DIV,
    parameter int DATA_W = MEM_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_enable_i,
    input  logic              serial_readWrite_i,
    input  logic              serial_dataSel_i,
    input  logic [DATA_W-1:0] serial_dataWrite_i,
    output logic [DATA_W-1:0] serial_dataRead_o,
    output logic              serial_sendComplete_o,
    output logic              serial_receiveComplete_o,
    input  logic              uart_rxd_i,
    output logic              uart_txd_o
);
    logic  wr_data, rd_data, rx_valid;
    byte_t rx_data, rx_hold;
    logic  unused_upper;

    assign wr_data = (serial_enable_i == ENABLE) & (serial_readWrite_i == MEM_WRITE) & serial_dataSel_i;
    assign rd_data = (serial_enable_i == ENABLE) & (serial_readWrite_i == MEM_READ) & serial_dataSel_i;
    assign unused_upper = |serial_dataWrite_i[DATA_W-1:8];
    assign serial_dataRead_o = {{(DATA_W - 8){1'b0}}, rx_hold};

    uart_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk(clk),
        .rst(rst),
        .start(wr_data),
        .data(serial_dataWrite_i[7:0]),
        .txd(uart_txd_o),
        .ready(serial_sendComplete_o)
    );

    uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk(clk),
        .rst(rst),
        .rxd(uart_rxd_i),
        .valid(rx_valid),
        .data(rx_data)
    );

    // A byte landing in the same cycle as a read keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_hold <= '0;
            serial_receiveComplete_o <= 1'b0;
        end else if (rx_valid) begin
            rx_hold <= rx_data;
            serial_receiveComplete_o <= 1'b1;
        end else if (rd_data) begin
            serial_receiveComplete_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_serial_ctrl.sv
// tb_uart_serial_ctrl: directed checks of the serial controller at CLK_DIV=16
module tb_uart_serial_ctrl;
    localparam int CLK_DIV = 16;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, rw = 1'b0, sel = 1'b0, rxd = 1'b1;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        txd, sc, rc;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    uart_serial_ctrl #(.CLK_DIV(CLK_DIV), .DATA_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .serial_enable_i(en),
        .serial_readWrite_i(rw),
        .serial_dataSel_i(sel),
        .serial_dataWrite_i(wdata),
        .serial_dataRead_o(rdata),
        .serial_sendComplete_o(sc),
        .serial_receiveComplete_o(rc),
        .uart_rxd_i(rxd),
        .uart_txd_o(txd)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input logic w, input logic s, input logic [15:0] d);
        en = 1'b1;
        rw = w;
        sel = s;
        wdata = d;
        @(posedge clk);
        #1;
        en = 1'b0;
        rw = 1'b0;
        sel = 1'b0;
    endtask

    task automatic tx_frame(input logic [15:0] d, input logic [7:0] exp_byte, input logic inject);
        logic [9:0] line = '0;
        access(1'b1, 1'b1, d);
        check("tx_start_txd", {15'b0, txd}, 16'd0);
        check("tx_start_busy", {15'b0, sc}, 16'd0);
        for (int c = 1; c <= 10 * CLK_DIV; c++) begin
            @(posedge clk);
            #1;
            if (c % CLK_DIV == CLK_DIV / 2) line[c / CLK_DIV] = txd;
            if (c == 40 && inject) begin
                en = 1'b1;
                rw = 1'b1;
                sel = 1'b1;
                wdata = 16'h0033;
            end else if (c == 41) begin
                en = 1'b0;
                sel = 1'b0;
            end
            if (c == 10 * CLK_DIV - 1) check("tx_busy_159", {15'b0, sc}, 16'd0);
        end
        check("tx_start_bit", {15'b0, line[0]}, 16'd0);
        check("tx_byte", {8'b0, line[8:1]}, {8'b0, exp_byte});
        check("tx_stop_bit", {15'b0, line[9]}, 16'd1);
        check("tx_done_160", {15'b0, sc}, 16'd1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            rxd = bits[j];
            repeat (CLK_DIV) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_txd", {15'b0, txd}, 16'd1);
        check("rst_send", {15'b0, sc}, 16'd1);
        check("rst_recv", {15'b0, rc}, 16'd0);
        check("rst_data", rdata, 16'h0000);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        tx_frame(16'hA955, 8'h55, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        tx_frame(16'h0055, 8'h55, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("tx_drop_idle_txd", {15'b0, txd}, 16'd1);
        check("tx_drop_idle_send", {15'b0, sc}, 16'd1);
        tx_frame(16'h0033, 8'h33, 1'b0);

        rx_frame(8'hC3, 1'b1);
        check("rx_flag", {15'b0, rc}, 16'd1);
        check("rx_data", rdata, 16'h00C3);
        access(1'b0, 1'b0, 16'h0000);
        check("rx_status_read_keeps", {15'b0, rc}, 16'd1);
        access(1'b0, 1'b1, 16'h0000);
        check("rx_read_clears", {15'b0, rc}, 16'd0);
        check("rx_read_retains", rdata, 16'h00C3);

        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("rx_glitch_flag", {15'b0, rc}, 16'd0);
        check("rx_glitch_data", rdata, 16'h00C3);

        rx_frame(8'h5A, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        check("rx_frame_err_flag", {15'b0, rc}, 16'd0);
        check("rx_frame_err_data", rdata, 16'h00C3);

        rx_frame(8'h11, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rx_frame(8'h22, 1'b1);
        check("rx_overrun_flag", {15'b0, rc}, 16'd1);
        check("rx_overrun_data", rdata, 16'h0022);
        repeat (4) @(posedge clk);
        #1;

        fork
            rx_frame(8'h7E, 1'b1);
            begin
                repeat (155) @(posedge clk);
                #1;
                en = 1'b1;
                rw = 1'b0;
                sel = 1'b1;
                @(posedge clk);
                #1;
                en = 1'b0;
                sel = 1'b0;
            end
        join
        check("rx_simul_flag", {15'b0, rc}, 16'd1);
        check("rx_simul_data", rdata, 16'h007E);

        access(1'b1, 1'b1, 16'h00F0);
        repeat (30) @(posedge clk);
        #1;
        check("tx_mid_busy", {15'b0, sc}, 16'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("tx_abort_txd", {15'b0, txd}, 16'd1);
        check("tx_abort_send", {15'b0, sc}, 16'd1);
        check("tx_abort_recv", {15'b0, rc}, 16'd0);
        check("tx_abort_data", rdata, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
